// File: rtl/fetch_seq_pkg.sv
// Shared opcode constants, state encodings and PC-select codes for the fetch sequencer.
package fetch_seq_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_LD      = 5'b10100;
    localparam logic [OPC_W-1:0] OPC_HLT     = 5'b10001;
    localparam logic [2:0]       OPC_JMP_PFX = 3'b111;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_LDB  = 3'd1,
        ST_JW1  = 3'd2,
        ST_JW2  = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: hold, increment (wrapping modulo 2^PC_W) or load a jump target.
module pc_reg
    import fetch_seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         sel,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_LOAD: pc_d = target;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end sequencer: owns the PC, decodes the fetched opcode and sequences load bubble, jump wait and halt.
// Optional macro STALL_PERF_CNT_EN adds a saturating 16-bit stall cycle counter output.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INS_W    = 20,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins_pm,
    input  logic             jmp_taken,
    input  logic [PC_W-1:0]  jmp_target,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             stall,
    output logic             flush,
    output logic             halted,
`ifdef STALL_PERF_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic [2:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic             flush_q;
    logic             flush_d;
    pc_sel_e          pc_sel;
    logic [OPC_W-1:0] opc;
    logic             unused_ins_bits;

    assign opc             = ins_pm[INS_W-1 -: OPC_W];
    assign unused_ins_bits = ^ins_pm[INS_W-OPC_W-1:0];

    // ins_pm is only decoded in RUN; every other state ignores the bus.
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        pc_sel  = PC_HOLD;
        stall   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (opc == OPC_LD) begin
                    stall   = 1'b1;
                    state_d = ST_LDB;
                end else if (opc[OPC_W-1 -: 3] == OPC_JMP_PFX) begin
                    stall   = 1'b1;
                    state_d = ST_JW1;
                end else if (opc == OPC_HLT) begin
                    stall   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    pc_sel = PC_INC;
                end
            end
            ST_LDB: begin
                pc_sel  = PC_INC;
                state_d = ST_RUN;
            end
            ST_JW1: begin
                stall   = 1'b1;
                state_d = ST_JW2;
            end
            ST_JW2: begin
                state_d = ST_RUN;
                if (jmp_taken) begin
                    pc_sel  = PC_LOAD;
                    flush_d = 1'b1;
                end else begin
                    pc_sel = PC_INC;
                end
            end
            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
                if (resume) begin
                    pc_sel  = PC_INC;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (reset),
        .sel    (pc_sel),
        .target (jmp_target),
        .pc     (pc)
    );

`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign fetch_en = ~stall;
    assign flush    = flush_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal expectations plus randomized traffic vs. a behavioural model.
module tb_fetch_sequencer;

    localparam logic [19:0] W_NORM = 20'h08000;
    localparam logic [19:0] W_LD   = 20'hA0000;
    localparam logic [19:0] W_JMP  = 20'hE0000;
    localparam logic [19:0] W_HLT  = 20'h88000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] ins_pm = W_NORM;
    logic        jmp_taken = 1'b0;
    logic [7:0]  jmp_target = 8'h00;
    logic        resume = 1'b0;
    logic [7:0]  pc;
    logic        fetch_en;
    logic        stall;
    logic        flush;
    logic        halted;
    logic [2:0]  state;
`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fetch_sequencer #(
        .PC_W     (8),
        .INS_W    (20),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ins_pm     (ins_pm),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .resume     (resume),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .stall      (stall),
        .flush      (flush),
        .halted     (halted),
`ifdef STALL_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: "what is the sequencer busy with" plus the remaining wait cycles.
    localparam int K_FETCH = 0, K_BUBBLE = 1, K_JWAIT = 2, K_HALT = 3;
    int          m_kind  = K_FETCH;
    int          m_left  = 0;
    logic [7:0]  m_pc    = 8'h00;
    logic        m_flush = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    function automatic bit is_ld(input logic [19:0] w);  return w[19:15] == 5'b10100; endfunction
    function automatic bit is_hlt(input logic [19:0] w); return w[19:15] == 5'b10001; endfunction
    function automatic bit is_jmp(input logic [19:0] w); return w[19:17] == 3'b111;   endfunction

    function automatic bit m_stall();
        case (m_kind)
            K_FETCH: return is_ld(ins_pm) || is_hlt(ins_pm) || is_jmp(ins_pm);
            K_JWAIT: return m_left != 0;
            K_HALT:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] m_state();
        case (m_kind)
            K_BUBBLE: return 3'd1;
            K_JWAIT:  return (m_left != 0) ? 3'd2 : 3'd3;
            K_HALT:   return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_kind  <= K_FETCH;
            m_left  <= 0;
            m_pc    <= 8'h00;
            m_flush <= 1'b0;
            m_cnt   <= 16'd0;
        end else begin
            if (m_stall() && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            m_flush <= 1'b0;
            case (m_kind)
                K_FETCH: begin
                    if (is_ld(ins_pm)) m_kind <= K_BUBBLE;
                    else if (is_jmp(ins_pm)) begin m_kind <= K_JWAIT; m_left <= 1; end
                    else if (is_hlt(ins_pm)) m_kind <= K_HALT;
                    else m_pc <= m_pc + 8'd1;
                end
                K_BUBBLE: begin m_pc <= m_pc + 8'd1; m_kind <= K_FETCH; end
                K_JWAIT: begin
                    if (m_left != 0) m_left <= m_left - 1;
                    else begin
                        if (jmp_taken) begin m_pc <= jmp_target; m_flush <= 1'b1; end
                        else m_pc <= m_pc + 8'd1;
                        m_kind <= K_FETCH;
                    end
                end
                K_HALT: if (resume) begin m_pc <= m_pc + 8'd1; m_kind <= K_FETCH; end
                default: m_kind <= K_FETCH;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", {24'd0, pc}, {24'd0, m_pc});
            check("state", {29'd0, state}, {29'd0, m_state()});
            check("stall", {31'd0, stall}, {31'd0, m_stall()});
            check("fetch_en", {31'd0, fetch_en}, {31'd0, ~m_stall()});
            check("halted", {31'd0, halted}, {31'd0, m_kind == K_HALT});
            check("flush", {31'd0, flush}, {31'd0, m_flush});
`ifdef STALL_PERF_CNT_EN
            check("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
`endif
        end
    end

    task automatic drive(input logic [19:0] ins, input logic jt, input logic [7:0] tgt, input logic res);
        ins_pm = ins; jmp_taken = jt; jmp_target = tgt; resume = res;
        @(posedge clk); #1;
    endtask

    task automatic jump_to(input logic [7:0] tgt);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b1, tgt, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] w;
        int          r;
`ifdef STALL_PERF_CNT_EN
        logic [15:0] c0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fetch_en", {31'd0, fetch_en}, 32'd1);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            drive(W_NORM, 1'b0, 8'h00, 1'b0);
            check("norm_pc", {24'd0, pc}, i);
            check("norm_flush", {31'd0, flush}, 32'd0);
        end
        repeat (2) drive(W_NORM, 1'b0, 8'h00, 1'b0);

        ins_pm = W_LD; #1;
        check("ld_stall", {31'd0, stall}, 32'd1);
        check("ld_pc", {24'd0, pc}, 32'h05);
        drive(W_LD, 1'b0, 8'h00, 1'b0);
        check("ldb_state", {29'd0, state}, 32'd1);
        check("ldb_stall", {31'd0, stall}, 32'd0);
        check("ldb_pc", {24'd0, pc}, 32'h05);
        drive(W_LD, 1'b0, 8'h00, 1'b0);
        check("ld_done_pc", {24'd0, pc}, 32'h06);
        check("ld_done_state", {29'd0, state}, 32'd0);
        repeat (10) drive(W_NORM, 1'b0, 8'h00, 1'b0);

        check("jmp_start_pc", {24'd0, pc}, 32'h10);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        check("jw1_state", {29'd0, state}, 32'd2);
        check("jw1_stall", {31'd0, stall}, 32'd1);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        check("jw2_stall", {31'd0, stall}, 32'd0);
        drive(W_JMP, 1'b1, 8'h40, 1'b0);
        check("jmp_pc", {24'd0, pc}, 32'h40);
        check("jmp_flush", {31'd0, flush}, 32'd1);
        drive(W_NORM, 1'b0, 8'h00, 1'b0);
        check("flush_clear", {31'd0, flush}, 32'd0);
        check("post_jmp_pc", {24'd0, pc}, 32'h41);

        jump_to(8'h10);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h99, 1'b0);
        check("nt_pc", {24'd0, pc}, 32'h11);
        check("nt_flush", {31'd0, flush}, 32'd0);

        jump_to(8'h20);
        drive(W_HLT, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(W_HLT, 1'b1, 8'h77, 1'b0);
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_pc", {24'd0, pc}, 32'h20);
        end
        drive(W_HLT, 1'b0, 8'h00, 1'b1);
        check("resume_pc", {24'd0, pc}, 32'h21);
        check("resume_halted", {31'd0, halted}, 32'd0);
        drive(W_NORM, 1'b0, 8'h00, 1'b1);
        check("run_resume_pc", {24'd0, pc}, 32'h22);

        jump_to(8'h33);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        check("pre_rst_state", {29'd0, state}, 32'd2);
        #2 ins_pm = W_NORM; reset = 1'b1;
        #1;
        check("async_pc", {24'd0, pc}, 32'h00);
        check("async_state", {29'd0, state}, 32'd0);
        check("async_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(W_NORM, 1'b0, 8'h00, 1'b0);
        check("post_rst_pc", {24'd0, pc}, 32'h01);
        check("post_rst_flush", {31'd0, flush}, 32'd0);

        jump_to(8'hFF);
        check("wrap_pre", {24'd0, pc}, 32'hFF);
        drive(W_NORM, 1'b0, 8'h00, 1'b0);
        check("wrap_pc", {24'd0, pc}, 32'h00);

`ifdef STALL_PERF_CNT_EN
        c0 = stall_cnt;
        drive(W_LD, 1'b0, 8'h00, 1'b0);
        drive(W_NORM, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        drive(W_JMP, 1'b0, 8'h00, 1'b0);
        check("stall_cnt_delta", {16'd0, stall_cnt - c0}, 32'd3);
`endif

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) w = W_LD | 20'($urandom_range(0, 32767));
            else if (r == 1) w = W_HLT | 20'($urandom_range(0, 32767));
            else if (r <= 3) w = {3'b111, 17'($urandom)};
            else begin
                w = 20'($urandom);
                while (is_ld(w) || is_hlt(w) || is_jmp(w)) w = 20'($urandom);
            end
            ins_pm = w;
            jmp_taken = 1'($urandom);
            jmp_target = 8'($urandom);
            resume = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(posedge clk); #1;
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
